// File: rtl/note_voice_allocator.sv
// Round-robin note request arbiter feeding a pool of note_sine_gen voices.
// Define VOICE_STEAL_EN to let a note-on overwrite the oldest voice when the pool is full.
module note_voice_allocator #(
  parameter int NUM_REQ    = 2,
  parameter int NUM_VOICES = 2,
  parameter int NOTE_W     = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_on,
  input  logic [NUM_REQ*NOTE_W-1:0]    req_note,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic                         drop_pulse,
  output logic                         steal_pulse
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t              state, state_nxt;
  logic [GW-1:0]       last_grant, grant, grant_sel;
  logic                grant_found;
  logic                cmd_on;
  logic [NOTE_W-1:0]   cmd_note;
  logic [NOTE_W-1:0]   note_q   [NUM_VOICES];
  logic [NOTE_W-1:0]   note_nxt [NUM_VOICES];
  logic [7:0]          age_q    [NUM_VOICES];
  logic [7:0]          age_nxt  [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_nxt, match;
  logic [NUM_REQ-1:0]  ready_nxt;
  logic                drop_nxt;
  logic                free_found, alloc;
  logic [VW-1:0]       free_idx, tgt_idx;
`ifdef VOICE_STEAL_EN
  logic                steal_nxt;
  logic [VW-1:0]       old_idx;
  logic [7:0]          old_age;
`endif

  // Scan starts one past the last winner so every held request is served within NUM_REQ grants.
  always_comb begin
    int idx;
    idx         = 0;
    grant_sel   = last_grant;
    grant_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_sel   = GW'(idx);
      end
    end
  end

  always_comb begin
    match      = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      match[v] = voice_active[v] && (note_q[v] == cmd_note);
      if (!free_found && !voice_active[v]) begin
        free_found = 1'b1;
        free_idx   = VW'(v);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  // Strict greater-than keeps the lowest index on equal ages.
  always_comb begin
    old_idx = '0;
    old_age = age_q[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_q[v] > old_age) begin
        old_age = age_q[v];
        old_idx = VW'(v);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_nxt  = '0;
    drop_nxt   = 1'b0;
    note_nxt   = note_q;
    age_nxt    = age_q;
    active_nxt = voice_active;
    alloc      = 1'b0;
    tgt_idx    = free_idx;
`ifdef VOICE_STEAL_EN
    steal_nxt  = 1'b0;
`endif
    if (state == IDLE && grant_found) ready_nxt[grant_sel] = 1'b1;

    if (state == EXEC && cmd_note != '0) begin
      if (!cmd_on) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (match[v]) begin
            note_nxt[v]   = '0;
            active_nxt[v] = 1'b0;
            age_nxt[v]    = 8'd0;
          end
        end
      end else if (|match) begin
        for (int v = 0; v < NUM_VOICES; v++)
          if (match[v]) age_nxt[v] = 8'd0;
      end else if (free_found) begin
        alloc = 1'b1;
      end else begin
`ifdef VOICE_STEAL_EN
        alloc     = 1'b1;
        tgt_idx   = old_idx;
        steal_nxt = 1'b1;
`else
        drop_nxt  = 1'b1;
`endif
      end

      if (alloc) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (VW'(v) == tgt_idx) begin
            note_nxt[v]   = cmd_note;
            active_nxt[v] = 1'b1;
            age_nxt[v]    = 8'd0;
          end else if (voice_active[v] && age_q[v] != 8'hFF) begin
            age_nxt[v] = age_q[v] + 8'd1;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GW'(NUM_REQ - 1);
      grant      <= '0;
      cmd_on     <= 1'b0;
      cmd_note   <= '0;
    end else if (state == IDLE && grant_found) begin
      grant      <= grant_sel;
      cmd_on     <= req_on[grant_sel];
      cmd_note   <= req_note[grant_sel*NOTE_W +: NOTE_W];
    end else if (state == EXEC) begin
      last_grant <= grant;
    end
  end

  // NOTE: the voice arrays are reset because a reset must silence every generator at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        age_q[v]  <= 8'd0;
      end
      voice_active <= '0;
      req_ready    <= '0;
      drop_pulse   <= 1'b0;
    end else begin
      note_q       <= note_nxt;
      age_q        <= age_nxt;
      voice_active <= active_nxt;
      req_ready    <= ready_nxt;
      drop_pulse   <= drop_nxt;
    end
  end

`ifdef VOICE_STEAL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) steal_pulse <= 1'b0;
    else       steal_pulse <= steal_nxt;
  end
`else
  assign steal_pulse = 1'b0;
`endif

  always_comb begin
    voice_note = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      voice_note[v*NOTE_W +: NOTE_W] = note_q[v];
  end

endmodule

// File: tb/tb_note_voice_allocator.sv
// Directed bench for note_voice_allocator; expectations follow VOICE_STEAL_EN when defined.
module tb_note_voice_allocator;

  localparam int NR = 2;
  localparam int NV = 2;
  localparam int NW = 6;
`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid, req_on, req_ready;
  logic [NR*NW-1:0]  req_note;
  logic [NV*NW-1:0]  voice_note;
  logic [NV-1:0]     voice_active;
  logic              drop_pulse, steal_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  note_voice_allocator #(.NUM_REQ(NR), .NUM_VOICES(NV), .NOTE_W(NW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_on(req_on), .req_note(req_note),
    .req_ready(req_ready), .voice_note(voice_note), .voice_active(voice_active),
    .drop_pulse(drop_pulse), .steal_pulse(steal_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] vn(input int v1, input int v0);
    return {20'd0, v1[5:0], v0[5:0]};
  endfunction

  // Present one request from requester idx, wait (bounded) for its ready, then release it.
  task automatic send(input int idx, input bit on, input int note, input string tag);
    int cyc;
    @(negedge clk);
    req_valid[idx]         = 1'b1;
    req_on[idx]            = on;
    req_note[idx*NW +: NW] = note[NW-1:0];
    cyc = 0;
    while (!req_ready[idx] && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, 1);
    @(posedge clk);
    #1 req_valid[idx] = 1'b0;
  endtask

  initial begin
    int ready_seen;
    req_valid = '0;
    req_on    = '0;
    req_note  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    ready_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready != '0) ready_seen++;
    end
    check("idle_ready", ready_seen, 0);
    check("idle_notes", voice_note, 0);
    check("idle_active", voice_active, 0);
    check("idle_drop", drop_pulse, 0);
    check("idle_steal", steal_pulse, 0);

    // Both requesters at once from reset: requester 0 wins, then 1.
    @(negedge clk);
    req_valid = 2'b11;
    req_on    = 2'b11;
    req_note  = {6'd7, 6'd3};
    @(negedge clk) check("pairA_first", req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    check("pairA_v0", voice_note, vn(0, 3));
    check("pairA_act0", voice_active, 2'b01);
    @(negedge clk);
    @(negedge clk) check("pairA_second", req_ready, 2'b10);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    check("pairA_v1", voice_note, vn(7, 3));
    check("pairA_act1", voice_active, 2'b11);

    // Pool full: voice 0 (note 3) is the older one.
    send(0, 1'b1, 9, "full");
    check("full_notes", voice_note, STEAL ? vn(7, 9) : vn(7, 3));
    check("full_steal", steal_pulse, STEAL);
    check("full_drop", drop_pulse, !STEAL);
    @(posedge clk);
    #1 check("full_pulses_once", {steal_pulse, drop_pulse}, 2'b00);

    send(0, 1'b1, 7, "retrig");
    check("retrig_notes", voice_note, STEAL ? vn(7, 9) : vn(7, 3));
    check("retrig_pulses", {steal_pulse, drop_pulse}, 2'b00);
    send(0, 1'b0, 10, "off_absent");
    check("off_absent_notes", voice_note, STEAL ? vn(7, 9) : vn(7, 3));
    check("off_absent_act", voice_active, 2'b11);

    send(0, 1'b0, STEAL ? 9 : 3, "clr0");
    send(0, 1'b0, 7, "clr1");
    check("clr_notes", voice_note, 0);
    check("clr_act", voice_active, 0);

    send(0, 1'b1, 5, "on5");
    check("on5_notes", voice_note, vn(0, 5));
    check("on5_act", voice_active, 2'b01);
    send(0, 1'b0, 5, "off5");
    check("off5_notes", voice_note, 0);
    check("off5_act", voice_active, 0);

    // Last grant was requester 0, so requester 1 wins this time.
    @(negedge clk);
    req_valid = 2'b11;
    req_on    = 2'b11;
    req_note  = {6'd7, 6'd3};
    @(negedge clk) check("pairB_first", req_ready, 2'b10);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    check("pairB_v0", voice_note, vn(0, 7));
    @(negedge clk);
    @(negedge clk) check("pairB_second", req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    check("pairB_v1", voice_note, vn(3, 7));

    // Reset asserted in the middle of an EXEC cycle.
    @(negedge clk);
    req_valid[0]    = 1'b1;
    req_on[0]       = 1'b1;
    req_note[0 +: NW] = 6'd12;
    @(posedge clk);
    #2 check("rst_pre_ready", req_ready, 2'b01);
    reset     = 1'b1;
    req_valid = '0;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_notes", voice_note, 0);
    check("rst_act", voice_active, 0);
    @(posedge clk);
    #1 check("rst_hold_ready", req_ready, 0);
    @(negedge clk) reset = 1'b0;
    send(0, 1'b1, 12, "post_rst");
    check("post_rst_notes", voice_note, vn(0, 12));
    check("post_rst_act", voice_active, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/note_voice_allocator.md
# note_voice_allocator

Arbitrates note-on/note-off requests from several sources (CPU speaker port, sequencer, test pattern) and assigns them to a fixed pool of note_sine_gen voice channels, replacing the fixed spk[7:6] channel decode. Each voice output drives one generator's 6-bit f_note; the generator outputs are mixed ahead of sigma_delta_dac. Round-robin request arbitration, free-voice search, optional oldest-voice stealing.

## Interface
- NUM_REQ, 2, number of requesters (1..4)
- NUM_VOICES, 2, number of voice channels (1..8)
- NOTE_W, 6, note index width; note 0 = silence
- clk  input  1  system clock (clk12 domain)
- reset  input  1  asynchronous, active-high; clears all state
- req_valid  input  NUM_REQ  request pending per requester; held until accepted
- req_on  input  NUM_REQ  1 = note-on, 0 = note-off
- req_note  input  NUM_REQ*NOTE_W  note per requester, requester i at [i*NOTE_W +: NOTE_W]
- req_ready  output  NUM_REQ  one-cycle accept pulse per requester
- voice_note  output  NUM_VOICES*NOTE_W  current note per voice, to note_sine_gen f_note
- voice_active  output  NUM_VOICES  voice holds a nonzero note
- drop_pulse  output  1  one-cycle pulse: note-on discarded, no voice available
- steal_pulse  output  1  one-cycle pulse: active voice overwritten

## Operation
- Two-state FSM: IDLE, EXEC. Reset -> IDLE.
- IDLE: if any req_valid, grant the first set requester scanning from last_grant+1 modulo NUM_REQ (reset value of last_grant = NUM_REQ-1, so requester 0 wins first). Latch grant, req_on, req_note; go EXEC. Otherwise stay.
- EXEC: req_ready[grant] = 1 for this cycle only; apply command; update last_grant; return to IDLE.
- Note-on, note 0: accepted, no voice change.
- Note-on, note already in a voice: no change; that voice's age reset to 0 (retrigger).
- Note-on, new note: lowest-index inactive voice gets note, age 0. No inactive voice: see Configuration.
- Note-off: every voice holding req_note cleared to 0, active cleared. No match: accepted, no effect. Note-off of note 0: no effect.
- Age: 8-bit per voice; on each note-on allocation, all other active voices increment, saturating at 255. Inactive voices hold age 0.
- Oldest voice = maximum age; ties -> lowest index.
- Requests are never lost while valid is held; a requester with valid high is granted within NUM_REQ grants.

## Timing
- Reset values: voice_note all 0, voice_active 0, req_ready 0, drop_pulse 0, steal_pulse 0, ages 0, FSM IDLE.
- All outputs registered. Request sampled at edge T (IDLE); req_ready high during cycle T..T+1; voice_note/voice_active/drop_pulse/steal_pulse updated at edge T+1 (EXEC edge), visible same cycle req_ready falls.
- Throughput: one request per 2 clocks. Requester deasserts valid (or presents next request) at the edge where it sees ready; block does not resample until the following edge.
- Simultaneous valid from multiple requesters: resolved only by round-robin; losers hold.
- Inputs changing while valid high before acceptance: value at IDLE sampling edge is used.
- Reset mid-EXEC: transaction aborted, no ready pulse, all voices silenced immediately (asynchronous).

## Configuration
- VOICE_STEAL_EN defined: new note-on with all voices active overwrites the oldest voice, age 0, steal_pulse for one cycle.
- VOICE_STEAL_EN undefined: that note-on is accepted (req_ready pulses) but discarded; drop_pulse for one cycle; voices unchanged. steal_pulse tied 0.

## Test plan
- Reset then idle 20 cycles -> all outputs 0, no ready.
- Req0 note-on 5 at edge T -> req_ready[0] high cycle T+1, voice_note[0]=5, voice_active=2'b01 at T+1; req0 note-off 5 -> voice 0 back to 0.
- Req0 and req1 both valid, notes 3 and 7 -> req0 granted first, req1 next grant; voices 0=3, 1=7; repeat with both -> req1 granted first.
- Voices hold 3 (older), 7; note-on 9: with VOICE_STEAL_EN voice 0=9, steal_pulse once; without, voices unchanged, drop_pulse once.
- Note-on 7 while 7 sounding -> no voice change, no pulses; note-off 10 (absent) -> accepted, no change.
- Assert reset during EXEC cycle -> req_ready stays 0, all voice_note 0 immediately; normal request after release works.
